picobus128_arbiter: RTL and testbench

Round-robin arbiter that shares one 128-bit PicoBus master port between NREQ internal requesters (host-command decoder, local sequencers, test engines). Each requester submits single read or write transactions through a valid/ready handshake. The block drives one-cycle PicoBus strobes to the slave register banks and returns read data to the originating requester. It sits between the requesters and the OR-combined PicoBus slave fabric, whose slaves drive 0 when not addressed.

---
 rtl/picobus128_pkg.sv | 14 +
 rtl/picobus128_arbiter_rr_picker.sv | 31 +++
 rtl/picobus128_arbiter.sv | 118 +++++++++++
 tb/tb_picobus128_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picobus128_pkg.sv
// rtl/picobus128_pkg.sv - shared PicoBus widths and arbiter FSM state encoding
package picobus128_pkg;

  localparam int PICO_ADDR_W = 32;
  localparam int PICO_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDCAP = 2'd2,
    RESP  = 2'd3
  } picoState_t;

endpackage

// File: rtl/picobus128_arbiter_rr_picker.sv
// rtl/picobus128_arbiter_rr_picker.sv - combinational round-robin winner select
// Search begins one past ptr so the most recently granted requester ranks last.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] reqValid,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grantIdx
);

  logic            found;
  logic [IDXW-1:0] cand;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(ptr) + k) % NREQ);
      if (!found && reqValid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grantIdx    = cand;
      end
    end
  end

endmodule

// File: rtl/picobus128_arbiter.sv
// rtl/picobus128_arbiter.sv - round-robin arbiter sharing one 128-bit PicoBus master port
// One transaction in flight at a time; reads return data to the originating requester.
module picobus128_arbiter
  import picobus128_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                        PicoClk,
  input  logic                        PicoRst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0]             req_wr,
  input  logic [PICO_ADDR_W*NREQ-1:0] req_addr,
  input  logic [PICO_DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [PICO_DATA_W-1:0]      rsp_data,
  output logic [PICO_ADDR_W-1:0]      BusAddr,
  output logic [PICO_DATA_W-1:0]      BusWrData,
  output logic                        BusRd,
  output logic                        BusWr,
  input  logic [PICO_DATA_W-1:0]      BusRdData
);

  localparam int IDXW = $clog2(NREQ);

  picoState_t             state;
  picoState_t             nextState;
  logic [IDXW-1:0]        ptr;
  logic [IDXW-1:0]        idxQ;
  logic                   wrQ;
  logic [PICO_ADDR_W-1:0] addrQ;
  logic [PICO_DATA_W-1:0] wdataQ;
  logic [PICO_DATA_W-1:0] rspDataQ;
  logic [NREQ-1:0]        pickGrant;
  logic [IDXW-1:0]        pickIdx;
  logic                   handshake;

  rr_picker #(
    .NREQ(NREQ),
    .IDXW(IDXW)
  ) u_picker (
    .reqValid(req_valid),
    .ptr     (ptr),
    .grant   (pickGrant),
    .grantIdx(pickIdx)
  );

  assign handshake = |(req_valid & req_ready);
  assign rsp_data  = rspDataQ;

  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Reset has priority over the RDCAP capture, so a dropped read leaves rsp_data cleared.
  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      ptr      <= IDXW'(NREQ - 1);
      idxQ     <= '0;
      wrQ      <= 1'b0;
      addrQ    <= '0;
      wdataQ   <= '0;
      rspDataQ <= '0;
    end else begin
      if (handshake) begin
        ptr    <= pickIdx;
        idxQ   <= pickIdx;
        wrQ    <= req_wr[pickIdx];
        addrQ  <= req_addr[int'(pickIdx)*PICO_ADDR_W +: PICO_ADDR_W];
        wdataQ <= req_wdata[int'(pickIdx)*PICO_DATA_W +: PICO_DATA_W];
      end
      if (state == RDCAP) begin
        rspDataQ <= BusRdData;
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (handshake) nextState = ISSUE;
      ISSUE:   nextState = wrQ ? IDLE : RDCAP;
      RDCAP:   nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus strobes come straight from the state register; only req_ready is masked by reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    BusRd     = 1'b0;
    BusWr     = 1'b0;
    BusAddr   = '0;
    BusWrData = '0;
    unique case (state)
      IDLE: begin
        if (!PicoRst) req_ready = pickGrant;
      end
      ISSUE: begin
        BusWr   = wrQ;
        BusRd   = !wrQ;
        BusAddr = addrQ;
        if (wrQ) BusWrData = wdataQ;
      end
      RESP: begin
        rsp_valid[idxQ] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_picobus128_arbiter.sv
// tb/tb_picobus128_arbiter.sv - scoreboard bench for the PicoBus round-robin arbiter
module tb_picobus128_arbiter;

  localparam int NREQ = 4;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
  } busExp_t;

  typedef struct {
    logic [3:0]   v;
    logic [127:0] d;
  } rspExp_t;

  logic           PicoClk = 1'b0;
  logic           PicoRst;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [3:0]     req_wr;
  logic [127:0]   req_addr;
  logic [511:0]   req_wdata;
  logic [3:0]     rsp_valid;
  logic [127:0]   rsp_data;
  logic [31:0]    BusAddr;
  logic [127:0]   BusWrData;
  logic           BusRd;
  logic           BusWr;
  logic [127:0]   BusRdData;

  logic [3:0]     grantQ[$];
  busExp_t        busQ[$];
  rspExp_t        rspQ[$];
  int             hsLog[$];
  int             cyc = 0;
  int             lastHs = 0;
  int             lastRd = 0;
  int             checks = 0;
  int             errors = 0;
  logic [127:0]   mem [logic [31:0]];

  localparam logic [127:0] D0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] D7 = 128'hCAFE0000_11112222_33334444_DEADBEEF;

  picobus128_arbiter #(.NREQ(NREQ)) dut (
    .PicoClk  (PicoClk),
    .PicoRst  (PicoRst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .BusAddr  (BusAddr),
    .BusWrData(BusWrData),
    .BusRd    (BusRd),
    .BusWr    (BusWr),
    .BusRdData(BusRdData)
  );

  always #5 PicoClk = ~PicoClk;

  always @(posedge PicoClk) cyc <= cyc + 1;

  // Slave fabric model: registered read data, zero when not read.
  always @(posedge PicoClk) begin
    if (BusWr) mem[BusAddr] = BusWrData;
    if (BusRd) BusRdData <= mem.exists(BusAddr) ? mem[BusAddr] : 128'h0;
    else       BusRdData <= 128'h0;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic failNote(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=present required=absent", nm);
  endtask

  always @(negedge PicoClk) begin
    if (|req_ready) begin
      if (grantQ.size() == 0) failNote("unexpected_grant");
      else chk("grant", 256'(req_ready), 256'(grantQ.pop_front()));
      lastHs = cyc;
      hsLog.push_back(cyc);
    end
    if (BusWr || BusRd) begin
      busExp_t e;
      chk("strobe_latency", 256'(cyc), 256'(lastHs + 1));
      if (busQ.size() == 0) failNote("unexpected_strobe");
      else begin
        e = busQ.pop_front();
        chk("bus_kind", 256'({BusWr, BusRd}), 256'({e.wr, !e.wr}));
        chk("bus_addr", 256'(BusAddr), 256'(e.addr));
        chk("bus_wdata", 256'(BusWrData), 256'(e.data));
      end
      if (BusRd) lastRd = cyc;
    end
    if (|rsp_valid) begin
      rspExp_t r;
      chk("rsp_latency", 256'(cyc), 256'(lastRd + 2));
      if (rspQ.size() == 0) failNote("unexpected_rsp");
      else begin
        r = rspQ.pop_front();
        chk("rsp_valid", 256'(rsp_valid), 256'(r.v));
        chk("rsp_data", 256'(rsp_data), 256'(r.d));
      end
    end
  end

  task automatic reqTxn(input int i, input logic wr, input logic [31:0] a, input logic [127:0] d);
    req_wr[i]               = wr;
    req_addr[32*i +: 32]    = a;
    req_wdata[128*i +: 128] = d;
    req_valid[i]            = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge PicoClk);
      if (req_ready[i]) begin
        @(posedge PicoClk);
        #1;
        req_valid[i] = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout actual=no_grant required=grant req=%0d", i);
    req_valid[i] = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge PicoClk);
    #1;
  endtask

  task automatic pushBus(input logic wr, input logic [31:0] a, input logic [127:0] d);
    busExp_t e;
    e.wr = wr; e.addr = a; e.data = d;
    busQ.push_back(e);
  endtask

  task automatic pushRsp(input logic [3:0] v, input logic [127:0] d);
    rspExp_t r;
    r.v = v; r.d = d;
    rspQ.push_back(r);
  endtask

  task automatic checkQuiet(input string tag);
    @(negedge PicoClk);
    chk({tag, "_req_ready"}, 256'(req_ready), 256'(0));
    chk({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
    chk({tag, "_rsp_data"}, 256'(rsp_data), 256'(0));
    chk({tag, "_bus_strobes"}, 256'({BusRd, BusWr}), 256'(0));
    chk({tag, "_bus_addr"}, 256'(BusAddr), 256'(0));
    chk({tag, "_bus_wdata"}, 256'(BusWrData), 256'(0));
  endtask

  initial begin
    PicoRst   = 1'b1;
    req_valid = 4'hF;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem[32'h30]  = 128'h5;
    mem[32'h100] = 128'hA1;
    mem[32'h110] = 128'hA2;
    mem[32'h120] = 128'hA3;
    mem[32'h200] = 128'hB1;
    mem[32'h210] = 128'hB2;
    repeat (2) @(posedge PicoClk);
    checkQuiet("reset");
    req_valid = '0;
    @(posedge PicoClk); #1;
    PicoRst = 1'b0;

    // Single write from req0.
    grantQ.push_back(4'b0001);
    pushBus(1'b1, 32'h10, D0);
    reqTxn(0, 1'b1, 32'h10, D0);
    idleCycles(4);

    // Single read from req1.
    grantQ.push_back(4'b0010);
    pushBus(1'b0, 32'h30, 128'h0);
    pushRsp(4'b0010, 128'h5);
    reqTxn(1, 1'b0, 32'h30, 128'h0);
    idleCycles(6);

    // Simultaneous writes straight after reset.
    PicoRst = 1'b1;
    idleCycles(2);
    PicoRst = 1'b0;
    hsLog.delete();
    for (int i = 0; i < 4; i++) begin
      grantQ.push_back(4'(1 << i));
      pushBus(1'b1, 32'h80 + 32'(i*16), 128'(i + 16'h1000));
    end
    grantQ.push_back(4'b0001);
    pushBus(1'b1, 32'h90, 128'h77);
    fork
      reqTxn(0, 1'b1, 32'h80, 128'h1000);
      reqTxn(1, 1'b1, 32'h90 - 32'h0, 128'h1001);
      reqTxn(2, 1'b1, 32'hA0, 128'h1002);
      reqTxn(3, 1'b1, 32'hB0, 128'h1003);
    join
    reqTxn(0, 1'b1, 32'h90, 128'h77);
    idleCycles(4);
    if (hsLog.size() < 4) failNote("grant_count_short");
    else for (int i = 1; i < 4; i++) chk("write_grant_spacing", 256'(hsLog[i] - hsLog[i-1]), 256'(2));

    // req2 streams reads, req0 joins mid-stream: 2,0,2,0,2.
    grantQ.push_back(4'b0100); pushBus(1'b0, 32'h100, 0); pushRsp(4'b0100, 128'hA1);
    grantQ.push_back(4'b0001); pushBus(1'b0, 32'h200, 0); pushRsp(4'b0001, 128'hB1);
    grantQ.push_back(4'b0100); pushBus(1'b0, 32'h110, 0); pushRsp(4'b0100, 128'hA2);
    grantQ.push_back(4'b0001); pushBus(1'b0, 32'h210, 0); pushRsp(4'b0001, 128'hB2);
    grantQ.push_back(4'b0100); pushBus(1'b0, 32'h120, 0); pushRsp(4'b0100, 128'hA3);
    fork
      begin
        reqTxn(2, 1'b0, 32'h100, 0);
        reqTxn(2, 1'b0, 32'h110, 0);
        reqTxn(2, 1'b0, 32'h120, 0);
      end
      begin
        idleCycles(2);
        reqTxn(0, 1'b0, 32'h200, 0);
        reqTxn(0, 1'b0, 32'h210, 0);
      end
    join
    idleCycles(6);

    // Reset during RDCAP of a req3 read drops the response.
    grantQ.push_back(4'b1000);
    pushBus(1'b0, 32'h40, 128'h0);
    reqTxn(3, 1'b0, 32'h40, 128'h0);
    @(posedge PicoClk); #1;
    PicoRst = 1'b1;
    @(posedge PicoClk); #1;
    PicoRst = 1'b0;
    checkQuiet("midreset");
    idleCycles(4);
    grantQ.push_back(4'b0001); pushBus(1'b1, 32'h50, 128'h55);
    grantQ.push_back(4'b1000); pushBus(1'b1, 32'h60, 128'h66);
    fork
      reqTxn(0, 1'b1, 32'h50, 128'h55);
      reqTxn(3, 1'b1, 32'h60, 128'h66);
    join
    idleCycles(4);

    // Write then read back through the slave model.
    grantQ.push_back(4'b0010); pushBus(1'b1, 32'h20, D7);
    grantQ.push_back(4'b0010); pushBus(1'b0, 32'h20, 128'h0); pushRsp(4'b0010, D7);
    reqTxn(1, 1'b1, 32'h20, D7);
    reqTxn(1, 1'b0, 32'h20, 128'h0);
    idleCycles(8);

    chk("grants_left", 256'(grantQ.size()), 256'(0));
    chk("strobes_left", 256'(busQ.size()), 256'(0));
    chk("rsps_left", 256'(rspQ.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
